divisor_ctrl: RTL and testbench
===============================

DIVISOR_CTRL -- requirements
Module: divisor_ctrl

Interface
REQ-001 Parameter: W, 18, width of divisor and counter.
REQ-002 Parameter: DIV_DEFAULT, 18'd200000, terminal count loaded at reset.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 Port: en  input  1  run enable; low holds the divider idle.
REQ-006 Port: load_req  input  1  request to install a new terminal count; held high until load_ack.
REQ-007 Port: load_div  input  W  requested terminal count; sampled in the cycle load_ack is asserted.
REQ-008 Port: load_ack  output  1  one-cycle pulse: load_div captured.
REQ-009 Port: s_clk  output  1  divided clock; toggles on each terminal count.
REQ-010 Port: tick  output  1  one-cycle pulse coincident with each s_clk toggle.
REQ-011 Port: busy  output  1  high while a captured divisor awaits installation.
REQ-012 Port: active_div  output  W  terminal count currently in use.

Function
REQ-013 The block SHALL implement three states: IDLE, RUN and PEND; IDLE is entered from reset.
REQ-014 In IDLE, the counter SHALL be held at 0, s_clk held at 0 and tick held at 0.
REQ-015 IDLE->RUN SHALL occur on the first edge with en=1; the counter starts at 0 on that edge.
REQ-016 In RUN/PEND, the counter SHALL increment by 1 per cycle; at counter==active_div it SHALL wrap to 0, toggle s_clk and pulse tick, giving an s_clk period of 2*(active_div+1) cycles.
REQ-017 The counter SHALL NOT exceed active_div; it SHALL NOT wrap modulo 2^W.
REQ-018 load_ack SHALL pulse for exactly one cycle, one cycle after load_req is sampled high in IDLE or RUN; it SHALL NOT pulse in PEND.
REQ-019 In IDLE, a captured value SHALL install into active_div on the ack edge, and busy SHALL stay low.
REQ-020 In RUN, a captured value SHALL go to a pending register, set busy and move to PEND.
REQ-021 In PEND, at the next terminal count the pending value SHALL install into active_div, the counter SHALL wrap to 0, busy SHALL clear and the state SHALL return to RUN.
REQ-022 load_div=0 SHALL be clamped to 1, so the minimum s_clk period is 4 cycles.
REQ-023 If load_req is high during PEND, it SHALL be acknowledged no earlier than the cycle after the return to RUN.
REQ-024 en=0 in RUN/PEND SHALL move the state to IDLE on the next edge, clear the counter and s_clk, and install any pending value into active_div.
REQ-025 If en falls and a terminal count occurs in the same cycle, en=0 SHALL take priority; no tick is emitted.

Reset
REQ-026 On reset, the block SHALL set: state=IDLE, counter=0, s_clk=0, tick=0, load_ack=0, busy=0, active_div=DIV_DEFAULT, pending=0.
REQ-027 Reset asserted mid-operation SHALL discard any pending value and any un-acked request.

Configuration
REQ-028 Macro DIVCTRL_IMMEDIATE_EN: when defined, a load accepted in RUN SHALL install into active_div on the ack edge and clear the counter to 0 with s_clk unchanged; PEND is never entered and busy stays 0.
REQ-029 When DIVCTRL_IMMEDIATE_EN is undefined, loads in RUN SHALL be deferred as in REQ-020/021.

Verification
REQ-030 Reset, then en=1 with DIV_DEFAULT overridden to 3 -> tick every 4 cycles, s_clk period 8 cycles, first toggle 4 cycles after enable.
REQ-031 In IDLE, load_req with load_div=5 -> load_ack one cycle later, active_div=5, busy=0; after en=1, tick every 6 cycles.
REQ-032 In RUN with active_div=3, load_div=7 at counter=1 -> busy=1 until the next terminal count, then active_div=7 and ticks every 8 cycles; a second request held during PEND is acked only after busy falls.
REQ-033 load_div=0 -> active_div=1, tick every 2 cycles; en dropped while PEND -> next cycle IDLE, s_clk=0, pending value installed.
REQ-034 Reset pulse mid-count with pending value -> outputs match REQ-026 asynchronously; active_div=DIV_DEFAULT.
REQ-035 With DIVCTRL_IMMEDIATE_EN defined, load_div=2 at counter=1 of active_div=5 -> counter=0 on the ack edge, busy never high, next tick 3 cycles later.

Source files
------------

// File: rtl/divisor_ctrl.sv
// divisor_ctrl: programmable clock divider with handshaked divisor loading.
// s_clk toggles every (active_div + 1) cycles while enabled; new divisors are
// taken over a load_req/load_ack handshake. In RUN a new divisor is parked in
// a pending register and installed at the next terminal count, keeping s_clk
// phases whole.
// Optional feature macro: DIVCTRL_IMMEDIATE_EN -- a load accepted in RUN
// installs at once and restarts the count (s_clk level kept, no PEND state).
module divisor_ctrl #(
    parameter int unsigned    W           = 18,
    parameter logic [W-1:0]   DIV_DEFAULT = W'(200000)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load_req,
    input  logic [W-1:0] load_div,
    output logic         load_ack,
    output logic         s_clk,
    output logic         tick,
    output logic         busy,
    output logic [W-1:0] active_div
);

    typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   act_q, act_d;
    logic [W-1:0]   pend_q, pend_d;
    logic           sclk_q, sclk_d;
    logic           tick_q, tick_d;
    logic           ack_q, ack_d;
    logic           busy_q, busy_d;

    logic [W-1:0]   load_clamped;
    logic           accept;
    logic           term;

    // Zero would give a degenerate divider; clamp to the minimum of 1.
    assign load_clamped = (load_div == '0) ? W'(1) : load_div;
    // ack_q blocks a second accept while the requester is still dropping load_req.
    assign accept       = load_req && !ack_q && (state_q != StPend);
    // >= rather than == so the counter can never run past the terminal count.
    assign term         = (cnt_q >= act_q);

    // Next-state and output decode for the divider FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        pend_d  = pend_q;
        sclk_d  = sclk_q;
        tick_d  = 1'b0;
        ack_d   = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                if (accept) begin
                    ack_d = 1'b1;
                    act_d = load_clamped;
                end
                if (en) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                if (!en) begin
                    // Disable wins over a coincident terminal count: no tick.
                    state_d = StIdle;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    if (accept) begin
                        ack_d = 1'b1;
                        act_d = load_clamped;
                    end
                end else begin
                    if (term) begin
                        cnt_d  = '0;
                        sclk_d = ~sclk_q;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                    if (accept) begin
                        ack_d = 1'b1;
`ifdef DIVCTRL_IMMEDIATE_EN
                        // Restart the count on the new divisor; the load takes
                        // priority over a coincident terminal count.
                        act_d  = load_clamped;
                        cnt_d  = '0;
                        sclk_d = sclk_q;
                        tick_d = 1'b0;
`else
                        pend_d  = load_clamped;
                        busy_d  = 1'b1;
                        state_d = StPend;
`endif
                    end
                end
            end

            StPend: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    act_d   = pend_q;
                    pend_d  = '0;
                    busy_d  = 1'b0;
                end else if (term) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    sclk_d  = ~sclk_q;
                    tick_d  = 1'b1;
                    act_d   = pend_q;
                    pend_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any pending divisor and un-acked request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            act_q   <= DIV_DEFAULT;
            pend_q  <= '0;
            sclk_q  <= 1'b0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            sclk_q  <= sclk_d;
            tick_q  <= tick_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign load_ack   = ack_q;
    assign s_clk      = sclk_q;
    assign tick       = tick_q;
    assign busy       = busy_q;
    assign active_div = act_q;

endmodule

// File: tb/tb_divisor_ctrl.sv
// Scoreboard bench for divisor_ctrl. The reference model predicts, from the
// divisor arithmetic alone, the absolute clock edge of every tick and ack;
// a monitor pops these expectations whenever the DUT pulses tick or load_ack.
module tb_divisor_ctrl;

    localparam int unsigned W = 18;
    localparam logic [W-1:0] DivDef = 18'd3;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         load_req;
    logic [W-1:0] load_div;
    logic         load_ack;
    logic         s_clk;
    logic         tick;
    logic         busy;
    logic [W-1:0] active_div;

    divisor_ctrl #(.W(W), .DIV_DEFAULT(DivDef)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load_req   (load_req),
        .load_div   (load_div),
        .load_ack   (load_ack),
        .s_clk      (s_clk),
        .tick       (tick),
        .busy       (busy),
        .active_div (active_div)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        sclk;
        int unsigned act;
        logic        busy;
    } tick_t;

    typedef struct {
        int unsigned cyc;
        int unsigned act;
        logic        busy;
    } ack_t;

    tick_t tick_exp[$];
    ack_t  ack_exp[$];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference model: divider running flag, edge of last tick/enable,
    // divisor in use, pending divisor, expected s_clk level.
    bit          m_run    = 0;
    int unsigned m_ref    = 0;
    int unsigned m_act    = DivDef;
    bit          m_pend_v = 0;
    int unsigned m_pend   = 0;
    logic        m_sclk   = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    endtask

    // Predict every tick up to and including edge e.
    task automatic advance(input int unsigned e);
        tick_t t;
        while (m_run && (m_ref + m_act + 1 <= e)) begin
            m_ref  = m_ref + m_act + 1;
            m_sclk = ~m_sclk;
            if (m_pend_v) begin
                m_act    = m_pend;
                m_pend_v = 0;
            end
            t.cyc  = m_ref;
            t.sclk = m_sclk;
            t.act  = m_act;
            t.busy = m_pend_v;
            tick_exp.push_back(t);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            step();
            advance(cyc + 1);
        end
    endtask

    task automatic enable();
        step();
        en    = 1'b1;
        m_run = 1;
        m_ref = cyc + 1;
    endtask

    task automatic disable_run();
        step();
        en = 1'b0;
        if (m_pend_v) begin
            m_act    = m_pend;
            m_pend_v = 0;
        end
        m_run  = 0;
        m_sclk = 1'b0;
        step();
        advance(cyc + 1);
        chk("disable s_clk", s_clk, 0);
        chk("disable busy", busy, 0);
        chk("disable active_div", active_div, m_act);
    endtask

    task automatic do_load(input int unsigned v);
        int unsigned vc;
        int unsigned ea;
        bit          seen;
        ack_t        a;
        tick_t       t;
        vc = (v == 0) ? 1 : v;
        step();
        load_req = 1'b1;
        load_div = W'(v);
        ea = cyc + 1;
        if (!m_run) begin
            m_act  = vc;
            a.cyc  = ea;
            a.act  = vc;
            a.busy = 0;
            ack_exp.push_back(a);
        end else begin
            // A request held during PEND is taken the edge after the install.
            if (m_pend_v) ea = m_ref + m_act + 2;
`ifdef DIVCTRL_IMMEDIATE_EN
            m_ref  = ea;
            m_act  = vc;
            a.cyc  = ea;
            a.act  = vc;
            a.busy = 0;
            ack_exp.push_back(a);
`else
            advance(ea);
            if (tick_exp.size() > 0 && tick_exp[$].cyc == ea) begin
                t      = tick_exp.pop_back();
                t.busy = 1;
                tick_exp.push_back(t);
            end
            a.cyc    = ea;
            a.act    = m_act;
            a.busy   = 1;
            ack_exp.push_back(a);
            m_pend_v = 1;
            m_pend   = vc;
`endif
        end
        seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            if (load_ack) begin
                seen     = 1;
                load_req = 1'b0;
            end
            advance(cyc + 1);
        end
        if (!seen) begin
            chk("load_ack timeout", 0, 1);
            load_req = 1'b0;
        end
    endtask

    task automatic reset_mid();
        step();
        en       = 1'b0;
        load_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async reset active_div", active_div, DivDef);
        chk("async reset busy", busy, 0);
        chk("async reset s_clk", s_clk, 0);
        chk("async reset tick", tick, 0);
        chk("async reset load_ack", load_ack, 0);
        m_run    = 0;
        m_pend_v = 0;
        m_act    = DivDef;
        m_sclk   = 1'b0;
        tick_exp.delete();
        ack_exp.delete();
        step();
        reset = 1'b0;
        advance(cyc + 1);
    endtask

    // Monitor: every DUT tick / ack must match the next predicted event.
    always @(negedge clk) begin
        if (!reset) begin
            if (tick) begin
                if (tick_exp.size() == 0) begin
                    chk("unexpected tick", 1, 0);
                end else begin
                    tick_t t;
                    t = tick_exp.pop_front();
                    chk("tick edge", cyc, t.cyc);
                    chk("tick s_clk", s_clk, t.sclk);
                    chk("tick active_div", active_div, t.act);
                    chk("tick busy", busy, t.busy);
                end
            end
            if (load_ack) begin
                if (ack_exp.size() == 0) begin
                    chk("unexpected load_ack", 1, 0);
                end else begin
                    ack_t a;
                    a = ack_exp.pop_front();
                    chk("ack edge", cyc, a.cyc);
                    chk("ack active_div", active_div, a.act);
                    chk("ack busy", busy, a.busy);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        load_req = 1'b0;
        load_div = '0;
        repeat (3) @(negedge clk);
        chk("reset active_div", active_div, DivDef);
        chk("reset s_clk", s_clk, 0);
        chk("reset tick", tick, 0);
        chk("reset busy", busy, 0);
        chk("reset load_ack", load_ack, 0);
        step();
        reset = 1'b0;
        advance(cyc + 1);

        // Default divisor of 3: tick every 4 cycles.
        idle(2);
        enable();
        idle(20);

        // Load in IDLE, then run on 5.
        disable_run();
        do_load(5);
        chk("idle load busy", busy, 0);
        enable();
        idle(20);

        // Deferred load with a second request held while pending.
        do_load(7);
        do_load(2);
        idle(30);

        // Zero clamps to 1.
        do_load(0);
        idle(16);

        // Disable while a divisor is pending.
        do_load(4);
        disable_run();
        idle(3);

        // Randomized loads, back-to-back requests and enable toggling.
        for (int it = 0; it < 14; it++) begin
            if (!m_run) enable();
            idle($urandom_range(0, 10));
            do_load($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) do_load($urandom_range(0, 9));
            idle($urandom_range(0, 25));
            if ($urandom_range(0, 3) == 0) begin
                disable_run();
                if ($urandom_range(0, 1) == 1) do_load($urandom_range(0, 9));
            end
        end

        // Reset with a divisor pending.
        if (!m_run) enable();
        idle(5);
        do_load(6);
        reset_mid();
        idle(4);
        enable();
        idle(12);

        disable_run();
        idle(4);
        chk("tick queue drained", tick_exp.size(), 0);
        chk("ack queue drained", ack_exp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
